// File: rtl/issue_pkg.sv
// Shared types for the issue group buffer: instruction class codes, the queued
// entry layout and small classification helpers.
package issue_pkg;

  localparam int ENTRY_PAYLOAD_W = 64;

  typedef enum logic [2:0] {
    ALU    = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    BRANCH = 3'd3,
    JAL    = 3'd4,
    JALR   = 3'd5
  } iclass_t;

  typedef struct packed {
    iclass_t    cls;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
  } uop_t;

  typedef struct packed {
    uop_t                       uop;
    logic [ENTRY_PAYLOAD_W-1:0] payload;
  } entry_t;

  function automatic logic is_mem(iclass_t cls);
    return (cls == LOAD) || (cls == STORE);
  endfunction

  function automatic logic is_ctrl(iclass_t cls);
    return (cls == BRANCH) || (cls == JAL) || (cls == JALR);
  endfunction

  // x0 never hazards, even if its mask bit were somehow set.
  function automatic logic reads_any(uop_t u, logic [31:0] mask);
    return (u.rs1_used && (u.rs1 != 5'd0) && mask[u.rs1]) ||
           (u.rs2_used && (u.rs2 != 5'd0) && mask[u.rs2]);
  endfunction

endpackage

// File: rtl/issue_hazard_check.sv
// Decides whether one candidate slot may join the group formed by the older
// slots ahead of it, given the load-use scoreboard mask.
module issue_hazard_check
  import issue_pkg::*;
#(
  parameter int SLOT      = 1,
  parameter int MEM_PORTS = 1
) (
  input  uop_t                 cand,
  input  logic [SLOT-1:0][2:0] older_cls,
  input  logic [SLOT-1:0][4:0] older_rd,
  input  logic [31:0]          sb_mask,
  output logic                 slot_ok
);

  logic ctrl_older;
  logic raw;
  logic waw;
  int   mem_cnt;

  always_comb begin
    ctrl_older = 1'b0;
    raw        = 1'b0;
    waw        = 1'b0;
    mem_cnt    = is_mem(cand.cls) ? 1 : 0;
    for (int j = 0; j < SLOT; j++) begin
      if (is_ctrl(iclass_t'(older_cls[j]))) ctrl_older = 1'b1;
      if (is_mem(iclass_t'(older_cls[j]))) mem_cnt = mem_cnt + 1;
      if (older_rd[j] != 5'd0) begin
        if ((cand.rs1_used && (cand.rs1 == older_rd[j])) ||
            (cand.rs2_used && (cand.rs2 == older_rd[j]))) raw = 1'b1;
        if (cand.rd == older_rd[j]) waw = 1'b1;
      end
    end
    slot_ok = !ctrl_older && !raw && !waw && (mem_cnt <= MEM_PORTS) &&
              !reads_any(cand, sb_mask);
  end

endmodule

// File: rtl/issue_group_buffer.sv
// Circular buffer between decode and dispatch that presents an in-order issue
// group of up to ISSUE_W instructions per cycle, gated by pairing rules and a
// load-use scoreboard.
module issue_group_buffer
  import issue_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int FETCH_W      = 2,
  parameter int ISSUE_W      = 2,
  parameter int MEM_PORTS    = 1,
  parameter int LOAD_USE_LAT = 1,
  parameter int PAYLOAD_W    = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [FETCH_W-1:0]           in_valid,
  input  logic [3*FETCH_W-1:0]         in_class,
  input  logic [5*FETCH_W-1:0]         in_rd,
  input  logic [5*FETCH_W-1:0]         in_rs1,
  input  logic [5*FETCH_W-1:0]         in_rs2,
  input  logic [FETCH_W-1:0]           in_rs1_used,
  input  logic [FETCH_W-1:0]           in_rs2_used,
  input  logic [PAYLOAD_W*FETCH_W-1:0] in_payload,
  output logic                         in_ready,
  output logic [ISSUE_W-1:0]           out_valid,
  output logic [3*ISSUE_W-1:0]         out_class,
  output logic [5*ISSUE_W-1:0]         out_rd,
  output logic [5*ISSUE_W-1:0]         out_rs1,
  output logic [5*ISSUE_W-1:0]         out_rs2,
  output logic [PAYLOAD_W*ISSUE_W-1:0] out_payload,
  input  logic                         out_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        sb_q [LOAD_USE_LAT];
  logic [31:0]        sb_d [LOAD_USE_LAT];
  logic [31:0]        sb_union;

  entry_t                    hd_ent [ISSUE_W];
  logic [ISSUE_W-1:0][2:0]   hd_cls;
  logic [ISSUE_W-1:0][4:0]   hd_rd;
  logic [ISSUE_W-1:0]        slot_ok;
  logic [ISSUE_W-1:0]        grp_valid;
  logic                      do_push;
  logic                      do_pop;
  logic [CNT_W-1:0]          push_n;
  logic [CNT_W-1:0]          pop_n;

  genvar gi;
  generate
    for (gi = 0; gi < ISSUE_W; gi++) begin : g_head
      assign hd_ent[gi] = mem_q[head_q + PTR_W'(gi)];
      assign hd_cls[gi] = hd_ent[gi].uop.cls;
      assign hd_rd[gi]  = hd_ent[gi].uop.rd;
      assign out_class[3*gi +: 3]           = hd_ent[gi].uop.cls;
      assign out_rd[5*gi +: 5]              = hd_ent[gi].uop.rd;
      assign out_rs1[5*gi +: 5]             = hd_ent[gi].uop.rs1;
      assign out_rs2[5*gi +: 5]             = hd_ent[gi].uop.rs2;
      assign out_payload[PAYLOAD_W*gi +: PAYLOAD_W] = hd_ent[gi].payload[PAYLOAD_W-1:0];
    end

    for (gi = 1; gi < ISSUE_W; gi++) begin : g_hz
      issue_hazard_check #(
        .SLOT      (gi),
        .MEM_PORTS (MEM_PORTS)
      ) u_hz (
        .cand      (hd_ent[gi].uop),
        .older_cls (hd_cls[gi-1:0]),
        .older_rd  (hd_rd[gi-1:0]),
        .sb_mask   (sb_union),
        .slot_ok   (slot_ok[gi])
      );
    end
  endgenerate

  // Slot 0 has no older slots, so only the scoreboard can hold it back.
  assign slot_ok[0] = !reads_any(hd_ent[0].uop, sb_union);

  always_comb begin
    sb_union = '0;
    for (int i = 0; i < LOAD_USE_LAT; i++) sb_union = sb_union | sb_q[i];
  end

  always_comb begin
    grp_valid    = '0;
    grp_valid[0] = !flush && (count_q != '0) && slot_ok[0];
    for (int k = 1; k < ISSUE_W; k++) begin
      grp_valid[k] = grp_valid[k-1] && (CNT_W'(k) < count_q) && slot_ok[k];
    end
  end

  assign out_valid = grp_valid;
  assign in_ready  = (count_q <= CNT_W'(DEPTH - FETCH_W));
  assign do_push   = in_ready && !flush;
  assign do_pop    = out_ready && !flush;

  always_comb begin
    mem_d  = mem_q;
    push_n = '0;
    pop_n  = '0;
    sb_d[0] = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      if (do_push && in_valid[i]) begin
        push_n = push_n + 1'b1;
        mem_d[tail_q + PTR_W'(i)] = '{
          uop: '{
            cls:      iclass_t'(in_class[3*i +: 3]),
            rd:       in_rd[5*i +: 5],
            rs1:      in_rs1[5*i +: 5],
            rs2:      in_rs2[5*i +: 5],
            rs1_used: in_rs1_used[i],
            rs2_used: in_rs2_used[i]
          },
          payload: ENTRY_PAYLOAD_W'(in_payload[PAYLOAD_W*i +: PAYLOAD_W])
        };
      end
    end
    for (int k = 0; k < ISSUE_W; k++) begin
      if (do_pop && grp_valid[k]) begin
        pop_n = pop_n + 1'b1;
        if (hd_ent[k].uop.cls == LOAD) sb_d[0][hd_rd[k]] = 1'b1;
      end
    end
    sb_d[0][0] = 1'b0;
    for (int i = 1; i < LOAD_USE_LAT; i++) sb_d[i] = sb_q[i-1];
    head_d  = head_q + PTR_W'(pop_n);
    tail_d  = tail_q + PTR_W'(push_n);
    count_d = count_q + push_n - pop_n;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < LOAD_USE_LAT; i++) sb_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < LOAD_USE_LAT; i++) sb_q[i] <= sb_d[i];
    end
  end

endmodule

// File: tb/tb_issue_group_buffer.sv
// Self-checking bench for issue_group_buffer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_issue_group_buffer;

  localparam int DEPTH     = 8;
  localparam int FETCH_W   = 2;
  localparam int ISSUE_W   = 2;
  localparam int MEM_PORTS = 1;
  localparam int LAT       = 3;
  localparam int PW        = 64;

  localparam int C_ALU = 0, C_LOAD = 1, C_STORE = 2, C_BRANCH = 3, C_JAL = 4, C_JALR = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush;
  logic [FETCH_W-1:0]      in_valid;
  logic [3*FETCH_W-1:0]    in_class;
  logic [5*FETCH_W-1:0]    in_rd, in_rs1, in_rs2;
  logic [FETCH_W-1:0]      in_rs1_used, in_rs2_used;
  logic [PW*FETCH_W-1:0]   in_payload;
  logic                    in_ready;
  logic [ISSUE_W-1:0]      out_valid;
  logic [3*ISSUE_W-1:0]    out_class;
  logic [5*ISSUE_W-1:0]    out_rd, out_rs1, out_rs2;
  logic [PW*ISSUE_W-1:0]   out_payload;
  logic                    out_ready;

  int checks = 0;
  int errors = 0;

  issue_group_buffer #(
    .DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W),
    .MEM_PORTS(MEM_PORTS), .LOAD_USE_LAT(LAT), .PAYLOAD_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_class(in_class), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
    .in_payload(in_payload), .in_ready(in_ready),
    .out_valid(out_valid), .out_class(out_class), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_payload(out_payload),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of instructions and, per register, the
  // first cycle at which a pending load result may be read.
  typedef struct {
    int          cls;
    int          rd;
    int          rs1;
    int          rs2;
    bit          u1;
    bit          u2;
    logic [63:0] pl;
  } ment_t;

  ment_t mq[$];
  int    ready_at[32];
  int    cyc = 0;

  function automatic bit reg_busy(int r, bit u);
    return u && (r != 0) && (cyc < ready_at[r]);
  endfunction

  function automatic bit is_mem_cls(int c);
    return (c == C_LOAD) || (c == C_STORE);
  endfunction

  function automatic int model_group();
    int    n;
    int    mem;
    bit    ok;
    ment_t e;
    n = 0;
    mem = 0;
    for (int k = 0; k < ISSUE_W && k < mq.size(); k++) begin
      e  = mq[k];
      ok = !(reg_busy(e.rs1, e.u1) || reg_busy(e.rs2, e.u2));
      for (int j = 0; j < k; j++) begin
        if (mq[j].rd != 0 && ((e.u1 && e.rs1 == mq[j].rd) ||
                              (e.u2 && e.rs2 == mq[j].rd) || e.rd == mq[j].rd)) ok = 0;
      end
      if (is_mem_cls(e.cls) && mem >= MEM_PORTS) ok = 0;
      if (!ok) break;
      if (is_mem_cls(e.cls)) mem++;
      n++;
      if (e.cls >= C_BRANCH) break;
    end
    return n;
  endfunction

  task automatic model_update();
    int    n;
    bit    can_push;
    ment_t e;
    if (rst || flush) begin
      mq.delete();
      for (int r = 0; r < 32; r++) ready_at[r] = 0;
    end else begin
      can_push = (mq.size() <= DEPTH - FETCH_W);
      n = model_group();
      if (out_ready) begin
        for (int k = 0; k < n; k++) begin
          e = mq.pop_front();
          if (e.cls == C_LOAD && e.rd != 0) ready_at[e.rd] = cyc + 1 + LAT;
        end
      end
      if (can_push) begin
        for (int i = 0; i < FETCH_W; i++) begin
          if (in_valid[i]) begin
            e.cls = int'(in_class[3*i +: 3]);
            e.rd  = int'(in_rd[5*i +: 5]);
            e.rs1 = int'(in_rs1[5*i +: 5]);
            e.rs2 = int'(in_rs2[5*i +: 5]);
            e.u1  = in_rs1_used[i];
            e.u2  = in_rs2_used[i];
            e.pl  = in_payload[PW*i +: PW];
            mq.push_back(e);
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_in();
    in_valid    = '0;
    in_class    = '0;
    in_rd       = '0;
    in_rs1      = '0;
    in_rs2      = '0;
    in_rs1_used = '0;
    in_rs2_used = '0;
    in_payload  = '0;
  endtask

  task automatic drive_slot(input int s, input int cls, input int rd, input int rs1,
                            input int rs2, input bit u1, input bit u2, input logic [63:0] pl);
    in_valid[s]           = 1'b1;
    in_class[3*s +: 3]    = 3'(cls);
    in_rd[5*s +: 5]       = 5'(rd);
    in_rs1[5*s +: 5]      = 5'(rs1);
    in_rs2[5*s +: 5]      = 5'(rs2);
    in_rs1_used[s]        = u1;
    in_rs2_used[s]        = u2;
    in_payload[PW*s +: PW] = pl;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; clear_in();
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 2'b00) begin errors++; $display("FAIL reset_out_valid got=%b exp=00", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_pair_alu();
    out_ready = 1'b1;
    drive_slot(0, C_ALU, 1, 2, 3, 1, 1, 64'h1111_0000_0000_0001);
    drive_slot(1, C_ALU, 4, 5, 6, 1, 1, 64'h2222_0000_0000_0002);
    #1;
    checks++;
    if (out_valid !== 2'b00) begin errors++; $display("FAIL pair_no_bypass got=%b exp=00", out_valid); end
    tick(); clear_in(); #1;
    checks++;
    if (out_valid !== 2'b11) begin errors++; $display("FAIL pair_valid got=%b exp=11", out_valid); end
    checks++;
    if (out_rd !== {5'd4, 5'd1}) begin errors++; $display("FAIL pair_rd got=%h exp=%h", out_rd, {5'd4, 5'd1}); end
    checks++;
    if (out_payload[PW +: PW] !== 64'h2222_0000_0000_0002) begin
      errors++; $display("FAIL pair_payload got=%h exp=2222000000000002", out_payload[PW +: PW]);
    end
    tick(); #1;
    checks++;
    if (out_valid !== 2'b00 || in_ready !== 1'b1) begin
      errors++; $display("FAIL pair_drained valid=%b ready=%b exp valid=00 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_raw();
    drive_slot(0, C_ALU, 1, 2, 3, 1, 1, 64'd10);
    drive_slot(1, C_ALU, 4, 1, 5, 1, 1, 64'd11);
    tick(); clear_in(); #1;
    checks++;
    if (out_valid !== 2'b01 || out_rd[4:0] !== 5'd1) begin
      errors++; $display("FAIL raw_first valid=%b rd=%0d exp valid=01 rd=1", out_valid, out_rd[4:0]);
    end
    tick(); #1;
    checks++;
    if (out_valid !== 2'b01 || out_rd[4:0] !== 5'd4) begin
      errors++; $display("FAIL raw_second valid=%b rd=%0d exp valid=01 rd=4", out_valid, out_rd[4:0]);
    end
    tick();
  endtask

  task automatic test_load_use();
    drive_slot(0, C_LOAD, 7, 2, 0, 1, 0, 64'd20);
    drive_slot(1, C_ALU, 8, 7, 1, 1, 1, 64'd21);
    tick(); clear_in(); #1;
    checks++;
    if (out_valid !== 2'b01 || out_class[2:0] !== 3'(C_LOAD)) begin
      errors++; $display("FAIL load_issue valid=%b cls=%0d exp valid=01 cls=1", out_valid, out_class[2:0]);
    end
    for (int d = 1; d <= LAT; d++) begin
      tick(); #1;
      checks++;
      if (out_valid !== 2'b00) begin
        errors++; $display("FAIL load_use_stall t+%0d got=%b exp=00", d, out_valid);
      end
    end
    tick(); #1;
    checks++;
    if (out_valid !== 2'b01 || out_rd[4:0] !== 5'd8) begin
      errors++; $display("FAIL load_use_release valid=%b rd=%0d exp valid=01 rd=8", out_valid, out_rd[4:0]);
    end
    tick();
  endtask

  task automatic test_mem_ports();
    drive_slot(0, C_LOAD, 9, 2, 0, 1, 0, 64'd30);
    drive_slot(1, C_STORE, 0, 2, 3, 1, 1, 64'd31);
    tick(); clear_in(); #1;
    checks++;
    if (out_valid !== 2'b01 || out_class[2:0] !== 3'(C_LOAD)) begin
      errors++; $display("FAIL mem_first valid=%b cls=%0d exp valid=01 cls=1", out_valid, out_class[2:0]);
    end
    tick(); #1;
    checks++;
    if (out_valid !== 2'b01 || out_class[2:0] !== 3'(C_STORE)) begin
      errors++; $display("FAIL mem_second valid=%b cls=%0d exp valid=01 cls=2", out_valid, out_class[2:0]);
    end
    tick();
  endtask

  task automatic test_branch();
    drive_slot(0, C_BRANCH, 0, 1, 2, 1, 1, 64'd40);
    drive_slot(1, C_ALU, 10, 11, 12, 1, 1, 64'd41);
    tick(); clear_in(); #1;
    checks++;
    if (out_valid !== 2'b01 || out_class[2:0] !== 3'(C_BRANCH)) begin
      errors++; $display("FAIL branch_alone valid=%b cls=%0d exp valid=01 cls=3", out_valid, out_class[2:0]);
    end
    tick(); #1;
    checks++;
    if (out_valid !== 2'b01 || out_rd[4:0] !== 5'd10) begin
      errors++; $display("FAIL branch_next valid=%b rd=%0d exp valid=01 rd=10", out_valid, out_rd[4:0]);
    end
    tick();
  endtask

  task automatic test_full_flush();
    out_ready = 1'b0;
    drive_slot(0, C_ALU, 1, 20, 21, 1, 1, 64'd50);
    for (int p = 0; p < 4; p++) begin
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready step=%0d got=%b exp=1", p, in_ready); end
      tick(); clear_in();
      if (p < 3) begin
        drive_slot(0, C_ALU, 2 + 2*p, 20, 21, 1, 1, 64'(51 + 2*p));
        drive_slot(1, C_ALU, 3 + 2*p, 20, 21, 1, 1, 64'(52 + 2*p));
      end
    end
    drive_slot(0, C_ALU, 30, 20, 21, 1, 1, 64'd90);
    drive_slot(1, C_ALU, 31, 20, 21, 1, 1, 64'd91);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    checks++;
    if (out_valid !== 2'b11) begin errors++; $display("FAIL full_group got=%b exp=11", out_valid); end
    tick(); #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 2'b11 || out_rd[4:0] !== 5'd1) begin
      errors++; $display("FAIL stall_stable ready=%b valid=%b rd=%0d exp ready=0 valid=11 rd=1",
                         in_ready, out_valid, out_rd[4:0]);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (out_valid !== 2'b00) begin errors++; $display("FAIL flush_cycle_valid got=%b exp=00", out_valid); end
    tick(); flush = 1'b0; clear_in(); #1;
    checks++;
    if (out_valid !== 2'b00 || in_ready !== 1'b1) begin
      errors++; $display("FAIL after_flush valid=%b ready=%b exp valid=00 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush_scoreboard();
    out_ready = 1'b1;
    drive_slot(0, C_LOAD, 7, 2, 0, 1, 0, 64'd60);
    tick(); clear_in(); #1;
    checks++;
    if (out_valid !== 2'b01) begin errors++; $display("FAIL sb_load_issue got=%b exp=01", out_valid); end
    tick();
    flush = 1'b1;
    drive_slot(0, C_ALU, 8, 7, 1, 1, 1, 64'd61);
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (out_valid !== 2'b00) begin errors++; $display("FAIL sb_push_ignored got=%b exp=00", out_valid); end
    tick(); clear_in(); #1;
    checks++;
    if (out_valid !== 2'b01 || out_rd[4:0] !== 5'd8) begin
      errors++; $display("FAIL sb_cleared valid=%b rd=%0d exp valid=01 rd=8", out_valid, out_rd[4:0]);
    end
    tick();
  endtask

  task automatic test_random();
    int                 nv;
    int                 n;
    int                 cls;
    bit                 u1;
    bit                 u2;
    int                 rd;
    logic [ISSUE_W-1:0] exp_mask;
    logic [17:0]        got_f;
    logic [17:0]        exp_f;
    for (int c = 0; c < 800; c++) begin
      clear_in();
      flush     = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      nv = $urandom_range(0, FETCH_W);
      for (int s = 0; s < nv; s++) begin
        cls = $urandom_range(0, 5);
        rd  = $urandom_range(0, 7);
        u1  = 1'b1;
        u2  = 1'($urandom_range(0, 1));
        if (cls == C_JAL || (cls == C_ALU && $urandom_range(0, 3) == 0)) begin
          u1 = 1'b0; u2 = 1'b0;
        end
        if (cls == C_STORE || cls == C_BRANCH) rd = 0;
        drive_slot(s, cls, rd, $urandom_range(0, 7), $urandom_range(0, 7), u1, u2,
                   {$urandom, $urandom});
      end
      #1;
      checks++;
      if (in_ready !== (mq.size() <= DEPTH - FETCH_W)) begin
        errors++; $display("FAIL rand_in_ready cyc=%0d got=%b count=%0d", cyc, in_ready, mq.size());
      end
      n = flush ? 0 : model_group();
      exp_mask = '0;
      for (int k = 0; k < n; k++) exp_mask[k] = 1'b1;
      checks++;
      if (out_valid !== exp_mask) begin
        errors++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_mask);
      end
      for (int k = 0; k < n; k++) begin
        got_f = {out_class[3*k +: 3], out_rd[5*k +: 5], out_rs1[5*k +: 5], out_rs2[5*k +: 5]};
        exp_f = {3'(mq[k].cls), 5'(mq[k].rd), 5'(mq[k].rs1), 5'(mq[k].rs2)};
        checks++;
        if (got_f !== exp_f || out_payload[PW*k +: PW] !== mq[k].pl) begin
          errors++;
          $display("FAIL rand_slot cyc=%0d k=%0d got=%h/%h exp=%h/%h", cyc, k, got_f,
                   out_payload[PW*k +: PW], exp_f, mq[k].pl);
        end
      end
      tick();
    end
    flush = 1'b0;
    clear_in();
  endtask

  initial begin
    test_reset();
    test_pair_alu();
    test_raw();
    test_load_use();
    test_mem_ports();
    test_branch();
    test_full_flush();
    test_flush_scoreboard();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_group_buffer.md
Name: issue_group_buffer

Overview:
- Parametrised successor to the fixed two-slot issue decision.
- Buffers decoded instructions from fetch/decode in a circular queue.
- Each cycle, forms an in-order issue group of up to ISSUE_W instructions from the head. Grouping applies generalised pairing rules plus a multi-cycle load-use scoreboard.
- Sits between decode and register read/dispatch in the multi-issue pipeline.

Parameters:
- DEPTH, 8: queue entries; power of two, at least FETCH_W and at least ISSUE_W.
- FETCH_W, 2: maximum instructions pushed per cycle.
- ISSUE_W, 2: maximum instructions per issue group, 1..4.
- MEM_PORTS, 1: maximum LOAD plus STORE instructions per group.
- LOAD_USE_LAT, 1: cycles after issue during which a load's rd may not be read, 1..3.
- PAYLOAD_W, 64: opaque per-instruction payload width (pc, imm, …), carried unchanged.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries and scoreboard state.
- in_valid  in  FETCH_W  per-slot push valid; contiguous from bit 0.
- in_class  in  3*FETCH_W  per-slot class code (package enum).
- in_rd  in  5*FETCH_W  destination register.
- in_rs1  in  5*FETCH_W  source register 1.
- in_rs2  in  5*FETCH_W  source register 2.
- in_rs1_used  in  FETCH_W  rs1 is a true source.
- in_rs2_used  in  FETCH_W  rs2 is a true source.
- in_payload  in  PAYLOAD_W*FETCH_W  opaque data.
- in_ready  out  1  buffer can accept FETCH_W entries this cycle.
- out_valid  out  ISSUE_W  group mask; contiguous from bit 0.
- out_class, out_rd, out_rs1, out_rs2, out_payload  out  packed per ISSUE_W slot, same widths as inputs  group contents; slot 0 is oldest.
- out_ready  in  1  downstream accepts the whole presented group.

Behaviour:
- Reset and flush take effect next edge. Effects:
  - head, tail and count go to 0.
  - All scoreboard masks go to 0.
  - out_valid is 0 after the edge.
  - in_ready is 1 after the edge.
  - During the flush cycle itself, out_valid is forced to 0 and pushes are ignored.
- in_ready = (count <= DEPTH-FETCH_W), computed from the registered count only; it does not anticipate a same-cycle pop.
- Push:
  - Occurs when in_ready && !flush.
  - popcount(in_valid) entries are written at tail in slot order.
  - Entries become visible the next cycle; there is no bypass.
- Group formation is combinational from registered state, over the head entries e0..e(ISSUE_W-1).
  - Slot 0 is valid iff count > 0 and e0 does not read a register in the scoreboard union mask.
  - Slot k (k ≥ 1) is valid iff all of the following hold:
    - slot k-1 is valid and k < count;
    - no older slot in the group has class BRANCH, JAL or JALR (control ends a group);
    - memory ops in slots 0..k do not exceed MEM_PORTS;
    - no RAW: for every older slot j with rd_j != 0, the used rs1/rs2 of ek ≠ rd_j;
    - no WAW: rd_k != 0 and rd_k == rd_j blocks;
    - ek reads no register in the scoreboard union mask.
  - A read from x0 never hazards. LUI, AUIPC and JAL have both *_used bits at 0.
- Pop:
  - Occurs when out_ready && !flush.
  - popcount(out_valid) entries are removed from head.
  - count_next = count + pushes - pops.
  - Pointers wrap modulo DEPTH.
- Scoreboard:
  - LOAD_USE_LAT stages, each a 32-bit mask.
  - Every cycle, stage i takes stage i-1.
  - Stage 0 takes the OR of one-hot(rd) over all LOAD slots in the group if the group was accepted this cycle; otherwise 0.
  - Bit 0 is always 0.
  - The union mask is the OR of all stages.
- Empty: out_valid is 0. A push into an empty buffer issues no earlier than the next cycle.
- Full: in_ready is 0. Push attempts are dropped; upstream must hold them.
- out_ready low: group contents stay stable only if no flush occurs. The scoreboard keeps aging.

Decomposition:
- Package issue_pkg holds:
  - The 3-bit class enum: ALU=0 (covers r, ri, lui, auipc), LOAD=1, STORE=2, BRANCH=3, JAL=4, JALR=5.
  - The packed entry struct (class, rd, rs1, rs2, rs1_used, rs2_used, payload).
  - Helper function is_mem(class).
- One sub-module, issue_hazard_check, evaluates a single candidate slot against the older slots and the scoreboard mask, returning slot_ok. Instantiate it ISSUE_W-1 times; slot 0 uses only the scoreboard part.

Test Plan:
- Push two ALU ops (add x1,x2,x3; add x4,x5,x6), out_ready=1 → next cycle out_valid=2'b11, count returns to 0.
- Push add x1,x2,x3 then sub x4,x1,x5 → group 1: out_valid=2'b01; group 2: sub alone, one cycle later.
- Push lw x7,0(x2) then add x8,x7,x1 with LOAD_USE_LAT=2 → lw issues at cycle t; add is withheld at t+1 and t+2, and issues at t+3.
- Push lw then sw (MEM_PORTS=1) → two single-slot groups. Repeat with MEM_PORTS=2 → one group of 2.
- Push beq then add (independent) → group {beq} only; add issues next cycle.
- Fill to DEPTH=8 with out_ready=0 → in_ready=0 at count 7. Assert flush with a push pending → next cycle count=0, out_valid=0, in_ready=1, scoreboard cleared.
